// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: unpacks a length-prefixed byte stream into 32-bit
// little-endian words, writes each one to IM, and holds the core in reset until the image is complete.
module im_loader #(
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned IM_BYTES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_byte,
  input  logic                i_byte_valid,
  output logic                o_byte_ready,
  output logic [IM_BYTES-1:0] o_we_im,
  output logic [31:0]         o_im_data,
  output logic                o_core_rst_n,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [15:0]         o_words_loaded
);

  typedef enum logic [1:0] {StLen, StData, StDone, StErr} state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] len_q, len_d;
  logic [31:0] shreg_q, shreg_d;
  logic        last_q, last_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [31:0] im_data_q, im_data_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] words_q, words_d;

  logic        xfer;
  logic [31:0] len_next;
  logic [31:0] word_next;

  assign xfer      = i_byte_valid & ready_q;
  assign len_next  = {i_byte, len_q[31:8]};
  assign word_next = {i_byte, shreg_q[31:8]};

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    len_d     = len_q;
    shreg_d   = shreg_q;
    last_d    = 1'b0;
    we_d      = 1'b0;
    im_data_d = im_data_q;
    words_d   = words_q;

    unique case (state_q)
      StLen: begin
        if (xfer) begin
          len_d  = len_next;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            if (len_next == 32'd0) begin
              state_d = StDone;
            end else if (len_next > MAX_WORDS) begin
              state_d = StErr;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (last_q) begin
          // Final strobe is on the port this cycle; leave once it has been issued.
          state_d = StDone;
        end else if (xfer) begin
          shreg_d = word_next;
          lane_d  = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d      = 1'b1;
            im_data_d = word_next;
            words_d   = (words_q == 16'(MAX_WORDS)) ? words_q : words_q + 16'd1;
            last_d    = (({16'd0, words_q} + 32'd1) == len_q);
          end
        end
      end
      StDone: ;
      StErr: ;
      default: state_d = StErr;
    endcase

    ready_d      = (state_d == StLen) || (state_d == StData);
    busy_d       = ready_d;
    done_d       = (state_d == StDone);
    error_d      = (state_d == StErr);
    // Release the core one cycle after DONE so the final IM write has settled.
    core_rst_n_d = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLen;
      lane_q       <= 2'd0;
      len_q        <= 32'd0;
      shreg_q      <= 32'd0;
      last_q       <= 1'b0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      im_data_q    <= 32'd0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      words_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      len_q        <= len_d;
      shreg_q      <= shreg_d;
      last_q       <= last_d;
      ready_q      <= ready_d;
      we_q         <= we_d;
      im_data_q    <= im_data_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      words_q      <= words_d;
    end
  end

  assign o_byte_ready   = ready_q;
  assign o_we_im        = {IM_BYTES{we_q}};
  assign o_im_data      = im_data_q;
  assign o_core_rst_n   = core_rst_n_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_words_loaded = words_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: a stream model predicts IM words, a monitor checks every strobe.
module tb_im_loader;

  localparam int unsigned MaxWords = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready;
  logic [3:0]  o_we_im;
  logic [31:0] o_im_data;
  logic        o_core_rst_n;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_words_loaded;

  always #5 clk = ~clk;

  im_loader #(.MAX_WORDS(MaxWords), .IM_BYTES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_byte        (i_byte),
    .i_byte_valid  (i_byte_valid),
    .o_byte_ready  (o_byte_ready),
    .o_we_im       (o_we_im),
    .o_im_data     (o_im_data),
    .o_core_rst_n  (o_core_rst_n),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_words_loaded(o_words_loaded)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  stim[$];
  int          cyc = 0;
  int          last_strobe = -1;
  bit          check_gap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must write all lanes and match the oldest predicted word.
  always @(negedge clk) begin
    if (o_we_im !== 4'h0) begin
      check("we_all_lanes", {28'd0, o_we_im}, 32'hF);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: data %h, no word outstanding", o_im_data);
      end else begin
        check("strobe_data", o_im_data, exp_q.pop_front());
      end
      if (check_gap && last_strobe >= 0) check("strobe_gap", 32'(cyc - last_strobe), 32'd4);
      last_strobe = cyc;
    end
  end

  // Reference model: the first four bytes are N (LE); each next group of four is one word.
  function automatic int unsigned expect_load();
    int unsigned n;
    n = {stim[3], stim[2], stim[1], stim[0]};
    if (n != 0 && n <= MaxWords) begin
      for (int w = 0; w < int'(n); w++) begin
        exp_q.push_back({stim[4*w+7], stim[4*w+6], stim[4*w+5], stim[4*w+4]});
      end
    end
    return n;
  endfunction

  function automatic void put_len(input int unsigned n);
    stim.push_back(n[7:0]);
    stim.push_back(n[15:8]);
    stim.push_back(n[23:16]);
    stim.push_back(n[31:24]);
  endfunction

  function automatic void put_rand(input int nbytes);
    for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, o_byte_ready}, 32'd0);
    check("rst_we", {28'd0, o_we_im}, 32'd0);
    check("rst_data", o_im_data, 32'd0);
    check("rst_flags", {28'd0, o_core_rst_n, o_busy, o_done, o_error}, 32'd0);
    check("rst_words", {16'd0, o_words_loaded}, 32'd0);
    last_strobe = -1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_busy", {30'd0, o_byte_ready, o_busy}, 32'd3);
  endtask

  // Presents stim bytes; a byte is committed when valid and the registered ready coincide.
  task automatic drive(input int pct, input int limit);
    int idx = 0;
    int cycles = 0;
    while (idx < stim.size()) begin
      @(negedge clk);
      i_byte_valid = ($urandom_range(99) < pct);
      i_byte = stim[idx];
      if (i_byte_valid && o_byte_ready) idx++;
      cycles++;
      if (cycles > limit) begin
        vectors++;
        miscompares++;
        $display("FAIL drive_timeout: %0d of %0d bytes accepted", idx, stim.size());
        break;
      end
    end
  endtask

  task automatic wait_end(input int unsigned n, input int exp_lat);
    int c = 0;
    @(negedge clk);
    i_byte_valid = 1'b0;
    while (!o_done && !o_error && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (c >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL end_timeout: neither done nor error after %0d cycles", c);
    end
    check("end_latency", 32'(c), 32'(exp_lat));
    check("end_ready_busy", {30'd0, o_byte_ready, o_busy}, 32'd0);
    if (n > MaxWords) begin
      check("err_flags", {30'd0, o_done, o_error}, 32'd1);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        check("err_core_held", {31'd0, o_core_rst_n}, 32'd0);
      end
      check("err_ready", {31'd0, o_byte_ready}, 32'd0);
    end else begin
      check("done_flags", {30'd0, o_done, o_error}, 32'd2);
      check("done_words", {16'd0, o_words_loaded}, n);
      check("core_rst_first", {31'd0, o_core_rst_n}, 32'd0);
      @(negedge clk);
      check("core_rst_release", {31'd0, o_core_rst_n}, 32'd1);
    end
    check("exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_load(input int pct);
    int unsigned n;
    n = expect_load();
    drive(pct, 20000);
    wait_end(n, (n == 0 || n > MaxWords) ? 0 : 1);
  endtask

  initial begin
    // 1: fixed two-word image, back to back
    do_reset();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
    run_load(100);

    // 2: same image with random valid gaps
    do_reset();
    run_load(50);

    // 3: empty image
    do_reset();
    stim.delete();
    put_len(0);
    run_load(100);

    // 4: one word over the limit, then the largest legal-plus-garbage count
    do_reset();
    stim.delete();
    put_len(MaxWords + 1);
    run_load(100);
    do_reset();
    stim.delete();
    put_len(32'hFFFF_FFFF);
    run_load(50);

    // 5: reset after six data bytes of a three-word load, then a fresh one-word load
    do_reset();
    stim.delete();
    put_len(3);
    put_rand(6);
    exp_q.push_back({stim[7], stim[6], stim[5], stim[4]});
    drive(100, 100);
    @(negedge clk);
    rst = 1'b1;
    i_byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_words_cleared", {16'd0, o_words_loaded}, 32'd0);
    check("abort_exp_drained", 32'(exp_q.size()), 32'd0);
    do_reset();
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(100);

    // Reset on the same edge as the final byte of a word: no strobe may follow.
    do_reset();
    stim.delete();
    put_len(1);
    put_rand(4);
    drive(100, 100);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wins_words", {16'd0, o_words_loaded}, 32'd0);
    i_byte_valid = 1'b0;

    // Random small images with stalls
    for (int k = 0; k < 4; k++) begin
      do_reset();
      stim.delete();
      put_len($urandom_range(1, 8));
      put_rand(4 * int'(stim[0]));
      run_load(50);
    end

    // 6: maximum image back to back, strobes every 4 cycles
    do_reset();
    stim.delete();
    put_len(MaxWords);
    put_rand(4 * MaxWords);
    check_gap = 1'b1;
    run_load(100);
    check_gap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_byte_valid = 1'b1;
      i_byte = 8'($urandom);
      check("post_done_ready", {31'd0, o_byte_ready}, 32'd0);
    end
    @(negedge clk);
    i_byte_valid = 1'b0;
    check("post_done_words", {16'd0, o_words_loaded}, MaxWords);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
